systolic_ctrl: RTL and testbench

Sequencer that drives the systolic datapath's control and address inputs. Runs one job as N tiles, with one fixed sequence per tile:
- PE clear
- register-file load from the IFM/WGT RAMs
- skewed compute
- result drain to the OFM RAM
It is the initiator side of the datapath's control interface. It replaces the bench-driven stimulus with a start/busy/done handshake.

---
 rtl/systolic_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic datapath: CLEAR -> LOAD -> WAIT -> COMPUTE -> DRAIN per tile.
// Optional cycle counter output is compiled in with `define SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
    parameter int SYSTOLIC_SIZE  = 16,
    parameter int BUFFER_SIZE    = 27,
    parameter int IFM_ADDR_WIDTH = 19,
    parameter int WGT_ADDR_WIDTH = 9,
    parameter int OFM_ADDR_WIDTH = 22,
    parameter int TILE_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TILE_WIDTH-1:0]     num_tiles,
    input  logic [IFM_ADDR_WIDTH-1:0] ifm_base,
    input  logic [WGT_ADDR_WIDTH-1:0] wgt_base,
    input  logic [OFM_ADDR_WIDTH-1:0] ofm_base,
    output logic                      busy,
    output logic                      done,
    output logic [IFM_ADDR_WIDTH-1:0] ifm_addr_a,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_addr_a,
    output logic                      read_en,
    output logic                      reset_pe,
    output logic                      write_out_en,
    output logic                      ofm_we_b,
    output logic [OFM_ADDR_WIDTH-1:0] ofm_addr_b
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]               cycle_count
`endif
);

    localparam int COMPUTE_LEN = BUFFER_SIZE + 2 * SYSTOLIC_SIZE - 1;
    localparam int CNT_W       = $clog2(COMPUTE_LEN + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(SYSTOLIC_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_nxt_s;
    logic [TILE_WIDTH-1:0]       t_r;
    logic [TILE_WIDTH-1:0]       tiles_r;
    logic [TILE_WIDTH:0]         t_inc_s;
    logic                        start_acc_s;

    logic [IFM_ADDR_WIDTH-1:0]   ifm_run_r;
    logic [WGT_ADDR_WIDTH-1:0]   wgt_base_r;
    logic [OFM_ADDR_WIDTH-1:0]   ofm_run_r;

    logic                        busy_r;
    logic                        done_r;
    logic                        read_en_r;
    logic                        reset_pe_r;
    logic                        write_out_en_r;
    logic                        ofm_we_r;
    logic [IFM_ADDR_WIDTH-1:0]   ifm_addr_r;
    logic [WGT_ADDR_WIDTH-1:0]   wgt_addr_r;
    logic [OFM_ADDR_WIDTH-1:0]   ofm_addr_r;

    logic                        busy_nxt_s;
    logic                        done_nxt_s;
    logic                        read_en_nxt_s;
    logic                        reset_pe_nxt_s;
    logic                        drain_nxt_s;
    logic [IFM_ADDR_WIDTH-1:0]   ifm_addr_nxt_s;
    logic [WGT_ADDR_WIDTH-1:0]   wgt_addr_nxt_s;
    logic [OFM_ADDR_WIDTH-1:0]   ofm_addr_nxt_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign t_inc_s     = {1'b0, t_r} + {{TILE_WIDTH{1'b0}}, 1'b1};

    // Next-state and in-state cycle counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_tiles == {TILE_WIDTH{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CLEAR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_nxt_s = ST_LOAD;
            ST_LOAD: begin
                if (cnt_r == LOAD_LAST) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_LOAD;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT: state_nxt_s = ST_COMPUTE;
            ST_COMPUTE: begin
                if (cnt_r == COMPUTE_LAST) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_NEXT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (t_inc_s < {1'b0, tiles_r}) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered
    always_comb begin
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        done_nxt_s     = (state_nxt_s == ST_DONE);
        reset_pe_nxt_s = (state_nxt_s == ST_CLEAR);
        read_en_nxt_s  = (state_nxt_s == ST_COMPUTE);
        drain_nxt_s    = (state_nxt_s == ST_DRAIN);
        ifm_addr_nxt_s = ifm_addr_r;
        wgt_addr_nxt_s = wgt_addr_r;
        ofm_addr_nxt_s = ofm_addr_r;
        if (state_nxt_s == ST_LOAD) begin
            ifm_addr_nxt_s = ifm_run_r + IFM_ADDR_WIDTH'(cnt_nxt_s);
            wgt_addr_nxt_s = wgt_base_r + WGT_ADDR_WIDTH'(cnt_nxt_s);
        end else begin
            ifm_addr_nxt_s = ifm_addr_r;
            wgt_addr_nxt_s = wgt_addr_r;
        end
        if (drain_nxt_s) begin
            ofm_addr_nxt_s = ofm_run_r + OFM_ADDR_WIDTH'(cnt_nxt_s);
        end else begin
            ofm_addr_nxt_s = ofm_addr_r;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Job parameters; tile bases advance by one tile stride in NEXT instead of t*stride
    always_ff @(posedge clk) begin
        if (rst) begin
            tiles_r    <= {TILE_WIDTH{1'b0}};
            t_r        <= {TILE_WIDTH{1'b0}};
            ifm_run_r  <= {IFM_ADDR_WIDTH{1'b0}};
            wgt_base_r <= {WGT_ADDR_WIDTH{1'b0}};
            ofm_run_r  <= {OFM_ADDR_WIDTH{1'b0}};
        end else if (start_acc_s) begin
            tiles_r    <= num_tiles;
            t_r        <= {TILE_WIDTH{1'b0}};
            ifm_run_r  <= ifm_base;
            wgt_base_r <= wgt_base;
            ofm_run_r  <= ofm_base;
        end else if (state_r == ST_NEXT) begin
            t_r       <= t_inc_s[TILE_WIDTH-1:0];
            ifm_run_r <= ifm_run_r + IFM_ADDR_WIDTH'(BUFFER_SIZE);
            ofm_run_r <= ofm_run_r + OFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            reset_pe_r     <= 1'b0;
            read_en_r      <= 1'b0;
            write_out_en_r <= 1'b0;
            ofm_we_r       <= 1'b0;
            ifm_addr_r     <= {IFM_ADDR_WIDTH{1'b0}};
            wgt_addr_r     <= {WGT_ADDR_WIDTH{1'b0}};
            ofm_addr_r     <= {OFM_ADDR_WIDTH{1'b0}};
        end else begin
            busy_r         <= busy_nxt_s;
            done_r         <= done_nxt_s;
            reset_pe_r     <= reset_pe_nxt_s;
            read_en_r      <= read_en_nxt_s;
            write_out_en_r <= drain_nxt_s;
            ofm_we_r       <= drain_nxt_s;
            ifm_addr_r     <= ifm_addr_nxt_s;
            wgt_addr_r     <= wgt_addr_nxt_s;
            ofm_addr_r     <= ofm_addr_nxt_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign reset_pe     = reset_pe_r;
    assign read_en      = read_en_r;
    assign write_out_en = write_out_en_r;
    assign ofm_we_b     = ofm_we_r;
    assign ifm_addr_a   = ifm_addr_r;
    assign wgt_addr_a   = wgt_addr_r;
    assign ofm_addr_b   = ofm_addr_r;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_r;

    // Busy-cycle counter, saturating, held while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_r <= 32'd0;
        end else if (start_acc_s) begin
            cycle_cnt_r <= 32'd0;
        end else if (busy_r && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt_r;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: each job pushes its expected per-cycle output trace.
module tb_systolic_ctrl;

    localparam int IFM_AW = 19;
    localparam int WGT_AW = 9;
    localparam int OFM_AW = 22;
    localparam int BS     = 27;
    localparam int SS     = 16;
    localparam int CL     = 58;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       num_tiles = 16'd0;
    logic [IFM_AW-1:0] ifm_base = '0;
    logic [WGT_AW-1:0] wgt_base = '0;
    logic [OFM_AW-1:0] ofm_base = '0;
    logic              busy, done, read_en, reset_pe, write_out_en, ofm_we_b;
    logic [IFM_AW-1:0] ifm_addr_a;
    logic [WGT_AW-1:0] wgt_addr_a;
    logic [OFM_AW-1:0] ofm_addr_b;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]       cycle_count;
`endif

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
        .busy(busy), .done(done), .ifm_addr_a(ifm_addr_a), .wgt_addr_a(wgt_addr_a),
        .read_en(read_en), .reset_pe(reset_pe), .write_out_en(write_out_en),
        .ofm_we_b(ofm_we_b), .ofm_addr_b(ofm_addr_b)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // ctrl = {busy, done, reset_pe, read_en, write_out_en, ofm_we_b}
    typedef struct packed {
        logic [5:0]        ctrl;
        logic [IFM_AW-1:0] ifm;
        logic [WGT_AW-1:0] wgt;
        logic [OFM_AW-1:0] ofm;
    } exp_t;

    exp_t              exp_q[$];
    logic [IFM_AW-1:0] gen_ifm = '0;
    logic [WGT_AW-1:0] gen_wgt = '0;
    logic [OFM_AW-1:0] gen_ofm = '0;
    int                tests_run = 0;
    int                tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: observed 0x%0h, required 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push_ctrl(input logic [5:0] c);
        exp_t e;
        e.ctrl = c;
        e.ifm  = gen_ifm;
        e.wgt  = gen_wgt;
        e.ofm  = gen_ofm;
        exp_q.push_back(e);
    endtask

    task automatic push_job(input int tiles, input logic [IFM_AW-1:0] ib,
                            input logic [WGT_AW-1:0] wb, input logic [OFM_AW-1:0] ob);
        for (int t = 0; t < tiles; t++) begin
            push_ctrl(6'b101000);
            for (int k = 0; k < BS; k++) begin
                gen_ifm = ib + IFM_AW'(t * BS + k);
                gen_wgt = wb + WGT_AW'(k);
                push_ctrl(6'b100000);
            end
            push_ctrl(6'b100000);
            for (int k = 0; k < CL; k++) push_ctrl(6'b100100);
            for (int j = 0; j < SS; j++) begin
                gen_ofm = ob + OFM_AW'(t * SS + j);
                push_ctrl(6'b100011);
            end
            push_ctrl(6'b100000);
        end
        push_ctrl(6'b110000);
    endtask

    // Output monitor: pops one expected cycle per clock, idle expectations when empty
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.ctrl = 6'b000000;
            e.ifm  = gen_ifm;
            e.wgt  = gen_wgt;
            e.ofm  = gen_ofm;
        end
        check_eq("ctrl", 64'({busy, done, reset_pe, read_en, write_out_en, ofm_we_b}), 64'(e.ctrl));
        check_eq("ifm_addr_a", 64'(ifm_addr_a), 64'(e.ifm));
        check_eq("wgt_addr_a", 64'(wgt_addr_a), 64'(e.wgt));
        check_eq("ofm_addr_b", 64'(ofm_addr_b), 64'(e.ofm));
    end

    task automatic start_job(input int tiles, input logic [IFM_AW-1:0] ib,
                             input logic [WGT_AW-1:0] wb, input logic [OFM_AW-1:0] ob);
        @(negedge clk);
        #1;
        num_tiles = 16'(tiles);
        ifm_base  = ib;
        wgt_base  = wb;
        ofm_base  = ob;
        start     = 1'b1;
        push_job(tiles, ib, wb, ob);
        @(negedge clk);
        #1;
        start     = 1'b0;
        num_tiles = 16'($urandom);
        ifm_base  = IFM_AW'($urandom);
        wgt_base  = WGT_AW'($urandom);
        ofm_base  = OFM_AW'($urandom);
    endtask

    task automatic wait_done(input int from_cyc, input int exp_cyc);
        int c;
        c = from_cyc;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_cycle", 64'(c), 64'(exp_cyc));
        @(negedge clk);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_eq("cycle_count", 64'(cycle_count), 64'(exp_cyc));
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input int tiles, input logic [IFM_AW-1:0] ib,
                           input logic [WGT_AW-1:0] wb, input logic [OFM_AW-1:0] ob);
        start_job(tiles, ib, wb, ob);
        wait_done(1, (tiles == 0) ? 1 : 104 * tiles + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job(1, 19'd100, 9'd0, 22'h200);
        run_job(2, 19'd100, 9'd0, 22'h200);
        run_job(0, 19'd5, 9'd6, 22'h7);

        // Mid-job start with different parameters must be ignored
        start_job(1, 19'd1000, 9'd20, 22'h1000);
        repeat (48) @(negedge clk);
        #1;
        start     = 1'b1;
        num_tiles = 16'd5;
        ifm_base  = 19'd7;
        wgt_base  = 9'd100;
        ofm_base  = 22'h55;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(50, 105);

        // Address wrap on all three address outputs
        run_job(1, 19'h7FFF0, 9'h1F0, 22'h3FFFF8);

        // Start held high through DONE restarts on the first IDLE cycle
        @(negedge clk);
        #1;
        num_tiles = 16'd0;
        start     = 1'b1;
        push_ctrl(6'b110000);
        push_ctrl(6'b000000);
        push_ctrl(6'b110000);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during COMPUTE of tile 0
        start_job(1, 19'd100, 9'd0, 22'h200);
        repeat (38) @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        gen_ifm = '0;
        gen_wgt = '0;
        gen_ofm = '0;
        @(negedge clk);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_eq("cycle_count_rst", 64'(cycle_count), 64'd0);
`endif
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_job(3, 19'd7, 9'd3, 22'h10);

        repeat (2) @(negedge clk);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
